// File: rtl/wb_interconnect.sv
`default_nettype none
// ============================================================================
// Module      : wb_interconnect
// Description : Single-master, NUM_SLAVES-slave Wishbone address decoder and
//               response router. A request is decoded in IDLE and then routed
//               to the selected slave in ACTIVE. An address that matches no
//               slave goes to ERROR, which pulses M_ERR for one cycle.
//               Incrementing bursts (CTI 010) stay on the same slave.
//               Optional stall timeout: define WB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_interconnect #(
  parameter int NUM_SLAVES = 6,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE = {32'h0000_2000, 32'h0000_1300,
      32'h0000_1200, 32'h0000_1100, 32'h0000_1000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK = {32'hFFFF_F000, 32'hFFFF_FF00,
      32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_F000},
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     M_CYC,
  input  logic                     M_STB,
  input  logic                     M_WE,
  input  logic [31:0]              M_ADR,
  input  logic [31:0]              M_DAT_O,
  input  logic [2:0]               M_CTI_O,
  output logic                     M_ACK,
  output logic                     M_ERR,
  output logic                     M_RTY,
  output logic [31:0]              M_DAT_I,
  output logic [NUM_SLAVES-1:0]    S_STB,
  output logic [NUM_SLAVES-1:0]    S_CYC,
  input  logic [NUM_SLAVES-1:0]    S_ACK,
  input  logic [NUM_SLAVES-1:0]    S_ERR,
  input  logic [NUM_SLAVES-1:0]    S_RTY,
  input  logic [32*NUM_SLAVES-1:0] S_DAT_I,
  output logic [31:0]              err_adr,
  output logic [7:0]               err_cnt
);

  // Slave index width covers the full legal range of 1..16 slaves.
  localparam int SEL_W = 4;
  localparam logic [2:0] CTI_INCR = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERROR  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [31:0]        err_adr_q, err_adr_d;
  logic [7:0]         err_cnt_q, err_cnt_d;

  logic               dec_hit;
  logic [SEL_W-1:0]   dec_idx;
  logic               sel_ack, sel_err, sel_rty;
  logic [31:0]        sel_dat;
  logic               term;
  logic               tmo_hit;

  // Address decode; scanning downward lets the lowest matching index win.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((M_ADR & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
        dec_hit = 1'b1;
        dec_idx = SEL_W'(i);
      end
    end
  end

  // Pick the response signals of the registered slave; others are ignored.
  always_comb begin
    sel_ack = 1'b0;
    sel_err = 1'b0;
    sel_rty = 1'b0;
    sel_dat = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q == SEL_W'(i)) begin
        sel_ack = S_ACK[i];
        sel_err = S_ERR[i];
        sel_rty = S_RTY[i];
        sel_dat = S_DAT_I[32*i +: 32];
      end
    end
  end

  assign term = sel_ack | sel_err | sel_rty;

`ifdef WB_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;

  // A slave termination in the same cycle takes priority over the timeout.
  assign tmo_hit = (state_q == ST_ACTIVE) && M_CYC && M_STB && !term &&
                   (tmo_q == 16'(TIMEOUT_CYCLES - 1));

  // Stall counter: cleared outside ACTIVE (so it starts at zero on entry) and on each termination.
  always_comb begin
    tmo_d = tmo_q;
    if (state_q != ST_ACTIVE || term) begin
      tmo_d = '0;
    end else if (M_STB) begin
      tmo_d = tmo_q + 16'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end

  logic unused_ok;
  assign unused_ok = ^{M_WE, M_DAT_O};
`else
  assign tmo_hit = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{M_WE, M_DAT_O, 32'(TIMEOUT_CYCLES)};
`endif

  // Next-state and output logic of the decode/route FSM.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    err_adr_d = err_adr_q;
    err_cnt_d = err_cnt_q;
    S_CYC     = '0;
    S_STB     = '0;
    M_ACK     = 1'b0;
    M_ERR     = 1'b0;
    M_RTY     = 1'b0;
    M_DAT_I   = '0;
    case (state_q)
      ST_IDLE: begin
        if (M_CYC && M_STB) begin
          if (dec_hit) begin
            sel_d   = dec_idx;
            state_d = ST_ACTIVE;
          end else begin
            err_adr_d = M_ADR;
            state_d   = ST_ERROR;
          end
        end
      end
      ST_ACTIVE: begin
        if (!M_CYC) begin
          state_d = ST_IDLE;
        end else begin
          for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q == SEL_W'(i)) begin
              S_CYC[i] = 1'b1;
              S_STB[i] = M_STB & ~tmo_hit;
            end
          end
          M_ACK   = sel_ack;
          M_ERR   = sel_err;
          M_RTY   = sel_rty;
          M_DAT_I = sel_dat;
          if (term) begin
            if (M_CTI_O != CTI_INCR) state_d = ST_IDLE;
          end else if (tmo_hit) begin
            err_adr_d = M_ADR;
            state_d   = ST_ERROR;
          end
        end
      end
      ST_ERROR: begin
        M_ERR = 1'b1;
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, selection and error-log registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      err_adr_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      err_adr_q <= err_adr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_adr = err_adr_q;
  assign err_cnt = err_cnt_q;

endmodule
`default_nettype wire
